// File: rtl/dual_modulus_divider.sv
// Dual-modulus feedback divider for a fractional-N loop.
// Divides the VCO clock by M = max(n_int, N_MIN) + sel for each output period.
// The DSM supplies sel, and div_pulse advances the DSM once per period.
// All outputs are registered: the pulse and clock flags are computed from the
// next-state values, so they line up with the state they describe.
module dual_modulus_divider #(
  parameter int CNT_W = 8,
  parameter int N_MIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] n_int,
  input  logic             sel,
  output logic             div_pulse,
  output logic             div_clk,
  output logic [CNT_W:0]   mod_cur
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [CNT_W:0] NMIN_M = (CNT_W + 1)'(N_MIN);
  localparam logic [CNT_W:0] ONE_M  = (CNT_W + 1)'(1);

  state_t         state_q, state_d;
  logic [CNT_W:0] cnt_q, cnt_d;
  logic [CNT_W:0] mod_q, mod_d;
  logic           pulse_q, pulse_d;
  logic           dclk_q, dclk_d;

  logic [CNT_W:0] n_ext, n_clamp, m_new, m_new_m1;

  // Modulus for the next period. The width is one bit wider than n_int so
  // that N = 2^CNT_W-1 plus sel does not wrap. The clamp is applied before
  // sel is added, so the shortest period is N_MIN cycles.
  assign n_ext    = {1'b0, n_int};
  assign n_clamp  = (n_ext < NMIN_M) ? NMIN_M : n_ext;
  assign m_new    = n_clamp + {{CNT_W{1'b0}}, sel};
  assign m_new_m1 = m_new - ONE_M;

  // Next-state logic. n_int and sel are sampled only on a load: either when
  // leaving IDLE or in the terminal cycle of a period.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        mod_d = NMIN_M;
        if (enable) begin
          state_d = RUN;
          mod_d   = m_new;
          cnt_d   = m_new_m1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          mod_d   = NMIN_M;
        end else if (cnt_q == '0) begin
          mod_d = m_new;
          cnt_d = m_new_m1;
        end else begin
          cnt_d = cnt_q - ONE_M;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        mod_d   = NMIN_M;
      end
    endcase
    pulse_d = (state_d == RUN) && (cnt_d == '0);
    dclk_d  = (state_d == RUN) && (cnt_d >= (mod_d >> 1));
  end

  // State and output registers with a synchronous reset that overrides enable.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mod_q   <= NMIN_M;
      pulse_q <= 1'b0;
      dclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      pulse_q <= pulse_d;
      dclk_q  <= dclk_d;
    end
  end

  assign div_pulse = pulse_q;
  assign div_clk   = dclk_q;
  assign mod_cur   = mod_q;

endmodule
